// File: rtl/gpu_frame_ram_pkg.sv
// Shared types and constants for the double-buffered framebuffer RAM.
// The scan-out logic imports the default frame size from here as well.
package gpu_frame_ram_pkg;

  localparam int DEFAULT_WIDTH  = 320;
  localparam int DEFAULT_HEIGHT = 200;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  // Bits needed to index n items, never less than one.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gpu_frame_ram_if.sv
// Bus bundle for gpu_frame_ram: scan-out read port, drawing port,
// clear engine and swap control. The master modport is the
// rasteriser/timing side; the slave modport is the RAM.
interface gpu_frame_ram_if
  import gpu_frame_ram_pkg::*;
#(
  parameter int XW  = clog2w(DEFAULT_WIDTH),
  parameter int YW  = clog2w(DEFAULT_HEIGHT),
  parameter int BPP = 1
);
  logic [XW-1:0]  x1;
  logic [YW-1:0]  y1;
  logic           en_read1;
  logic [BPP-1:0] rd_data1;
  logic           rd_valid1;

  logic [XW-1:0]  x2;
  logic [YW-1:0]  y2;
  logic           en_read2;
  logic           en_write2;
  logic [BPP-1:0] wr_data2;
  logic [BPP-1:0] rd_data2;
  logic           rd_valid2;

  logic           clear_req;
  logic [BPP-1:0] clear_value;
  logic           busy;
  logic           clear_done;

  logic           swap_req;
  logic           frame_sync;
  logic           swap_pending;
  logic           front_sel;
  logic           swap_done;

  modport master (
    output x1, y1, en_read1, x2, y2, en_read2, en_write2, wr_data2,
           clear_req, clear_value, swap_req, frame_sync,
    input  rd_data1, rd_valid1, rd_data2, rd_valid2, busy, clear_done,
           swap_pending, front_sel, swap_done
  );

  modport slave (
    input  x1, y1, en_read1, x2, y2, en_read2, en_write2, wr_data2,
           clear_req, clear_value, swap_req, frame_sync,
    output rd_data1, rd_valid1, rd_data2, rd_valid2, busy, clear_done,
           swap_pending, front_sel, swap_done
  );

endinterface

// File: rtl/gpu_frame_ram_bank.sv
// One storage bank: true dual-port DW x 2^AW RAM, read-first on both ports.
// i_en_* loads the port's read register; i_we_* writes the array.
module gpu_frame_ram_bank #(
  parameter int DW = 1,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en_a,
  input  logic          i_we_a,
  input  logic [AW-1:0] i_addr_a,
  input  logic [DW-1:0] i_wdata_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic          i_en_b,
  input  logic          i_we_b,
  input  logic [AW-1:0] i_addr_b,
  input  logic [DW-1:0] i_wdata_b,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata_a;
  logic [DW-1:0] r_rdata_b;

  // Array writes from both ports.
  // NOTE: the array sits in a clock-only process with no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
    if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;
  end

  // Read registers; they hold their value while the port is not enabled.
  // NOTE: non-blocking assignment samples the pre-write array contents, giving read-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      if (i_en_a) r_rdata_a <= r_mem[i_addr_a];
      if (i_en_b) r_rdata_b <= r_mem[i_addr_b];
    end
  end

  assign o_rdata_a = r_rdata_a;
  assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/gpu_frame_ram.sv
// Double-buffered framebuffer RAM. Port 1 reads the front buffer for
// scan-out; port 2 reads/writes the back buffer; a clear engine fills
// the back buffer; front/back swap on frame_sync once armed.
// Optional macro GPU_FRAME_RAM_BOUNDS_CHECK_EN: out-of-range coordinates
// are kept away from memory and read back as zero.
module gpu_frame_ram
  import gpu_frame_ram_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int HEIGHT      = DEFAULT_HEIGHT,
  parameter int BPP         = 1,
  parameter int BANK_ADDR_W = 14
) (
  input logic            clk,
  input logic            rst_n,
  gpu_frame_ram_if.slave bus
);

  localparam int PIX   = WIDTH * HEIGHT;
  localparam int PW    = clog2w(PIX);
  localparam int WORDS = 1 << BANK_ADDR_W;
  localparam int NB    = (PIX + WORDS - 1) / WORDS;
  localparam int BSW   = clog2w(NB);
  localparam int NI    = 2 * NB;
  localparam int IW    = clog2w(NI);

  clr_state_t       r_state, w_state_nxt;
  logic [PW-1:0]    r_cnt, w_cnt_nxt;
  logic [BPP-1:0]   r_clr_val, w_clr_val_nxt;
  logic             r_front_sel, r_swap_pending, r_swap_done;
  logic             r_valid1, r_valid2, r_oob1, r_oob2;
  logic [IW-1:0]    r_inst1, r_inst2;

  logic             w_busy, w_back_sel, w_do_swap;
  logic             w_oob1, w_oob2, w_rd1, w_rd2_req;
  logic [PW-1:0]    w_pix1, w_pix2, w_b_pix;
  logic [BSW-1:0]   w_bank1, w_bank_b;
  logic [BANK_ADDR_W-1:0] w_addr1, w_addr_b;
  logic [IW-1:0]    w_inst1, w_inst_b;
  logic             w_b_rd, w_b_wr;
  logic [BPP-1:0]   w_b_data;
  logic [BPP-1:0]   w_rdata_a [NI];
  logic [BPP-1:0]   w_rdata_b [NI];

  assign w_busy     = (r_state == ST_CLEAR);
  assign w_back_sel = ~r_front_sel;

`ifdef GPU_FRAME_RAM_BOUNDS_CHECK_EN
  assign w_oob1 = (32'(bus.x1) >= WIDTH) || (32'(bus.y1) >= HEIGHT);
  assign w_oob2 = (32'(bus.x2) >= WIDTH) || (32'(bus.y2) >= HEIGHT);
`else
  assign w_oob1 = 1'b0;
  assign w_oob2 = 1'b0;
`endif

  // Linear pixel index y*WIDTH + x; high bits pick the bank, low bits the word.
  assign w_pix1  = PW'(32'(bus.y1) * 32'(WIDTH) + 32'(bus.x1));
  assign w_pix2  = PW'(32'(bus.y2) * 32'(WIDTH) + 32'(bus.x2));
  assign w_bank1 = BSW'(w_pix1 >> BANK_ADDR_W);
  assign w_addr1 = BANK_ADDR_W'(w_pix1);
  assign w_inst1 = IW'(32'(r_front_sel) * NB + 32'(w_bank1));
  assign w_rd1   = bus.en_read1 && !w_oob1;

  assign w_rd2_req = bus.en_read2 && !w_busy;

  // Back-buffer port owner: the clear engine while busy, otherwise port 2.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    w_b_rd   = 1'b0;
    w_b_wr   = 1'b0;
    w_b_pix  = w_pix2;
    w_b_data = bus.wr_data2;
    if (w_busy) begin
      w_b_wr   = 1'b1;
      w_b_pix  = r_cnt;
      w_b_data = r_clr_val;
    end else begin
      w_b_rd = bus.en_read2  && !w_oob2;
      w_b_wr = bus.en_write2 && !w_oob2;
    end
  end

  assign w_bank_b = BSW'(w_b_pix >> BANK_ADDR_W);
  assign w_addr_b = BANK_ADDR_W'(w_b_pix);
  assign w_inst_b = IW'(32'(w_back_sel) * NB + 32'(w_bank_b));

  // Instances 0..NB-1 hold buffer 0, NB..2*NB-1 hold buffer 1.
  for (genvar gi = 0; gi < NI; gi++) begin : g_bank
    gpu_frame_ram_bank #(.DW(BPP), .AW(BANK_ADDR_W)) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en_a    (w_rd1 && (w_inst1 == IW'(gi))),
      .i_we_a    (1'b0),
      .i_addr_a  (w_addr1),
      .i_wdata_a ('0),
      .o_rdata_a (w_rdata_a[gi]),
      .i_en_b    (w_b_rd && (w_inst_b == IW'(gi))),
      .i_we_b    (w_b_wr && (w_inst_b == IW'(gi))),
      .i_addr_b  (w_addr_b),
      .i_wdata_b (w_b_data),
      .o_rdata_b (w_rdata_b[gi])
    );
  end

  // Read-side bookkeeping: valid strobes and the bank/buffer select for output muxing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid1 <= 1'b0;
      r_valid2 <= 1'b0;
      r_inst1  <= '0;
      r_inst2  <= '0;
      r_oob1   <= 1'b0;
      r_oob2   <= 1'b0;
    end else begin
      r_valid1 <= bus.en_read1;
      r_valid2 <= w_rd2_req;
      if (bus.en_read1) begin
        r_inst1 <= w_inst1;
        r_oob1  <= w_oob1;
      end
      if (w_rd2_req) begin
        r_inst2 <= w_inst_b;
        r_oob2  <= w_oob2;
      end
    end
  end

  // Clear FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_clr_val <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_clr_val <= w_clr_val_nxt;
    end
  end

  // Clear FSM next state: sweep every pixel once, then a one-cycle DONE.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_clr_val_nxt = r_clr_val;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.clear_req) begin
          w_state_nxt   = ST_CLEAR;
          w_cnt_nxt     = '0;
          w_clr_val_nxt = bus.clear_value;
        end
      end
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + PW'(1);
        if (r_cnt == PW'(PIX - 1)) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A swap is only taken at frame_sync while the clear engine is idle.
  assign w_do_swap = bus.frame_sync && (r_swap_pending || bus.swap_req) &&
                     (r_state == ST_IDLE);

  // Swap arming and front/back toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_swap_done    <= 1'b0;
    end else begin
      r_swap_done <= 1'b0;
      if (w_do_swap) begin
        r_front_sel    <= ~r_front_sel;
        r_swap_pending <= 1'b0;
        r_swap_done    <= 1'b1;
      end else if (bus.swap_req) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  assign bus.rd_data1     = r_oob1 ? '0 : w_rdata_a[r_inst1];
  assign bus.rd_valid1    = r_valid1;
  assign bus.rd_data2     = r_oob2 ? '0 : w_rdata_b[r_inst2];
  assign bus.rd_valid2    = r_valid2;
  assign bus.busy         = w_busy;
  assign bus.clear_done   = (r_state == ST_DONE);
  assign bus.swap_pending = r_swap_pending;
  assign bus.front_sel    = r_front_sel;
  assign bus.swap_done    = r_swap_done;

endmodule
